// File: rtl/vadd_result_stage.sv
// Result stage behind the guard-bit vector adder: strips guard bits, derives per-element
// carry / less-than flags, applies min/max select, and hands results on via valid/ready.
module vadd_result_stage #(
  parameter int unsigned REQ_DATA_WIDTH  = 64,
  parameter int unsigned RESP_DATA_WIDTH = 64,
  parameter int unsigned SEW_WIDTH       = 2,
  parameter bit          ENABLE_64_BIT   = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [RESP_DATA_WIDTH+16:0] sum,
  input  logic [REQ_DATA_WIDTH-1:0]  vec0,
  input  logic [REQ_DATA_WIDTH-1:0]  vec1,
  input  logic [SEW_WIDTH-1:0]       sew,
  input  logic [1:0]                 op,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [RESP_DATA_WIDTH-1:0] out_data,
  output logic [7:0]                 out_mask
);

  // Eight byte lanes; the element-index arithmetic below relies on that.
  localparam int unsigned Lanes = 8;

  // Stage 1 state
  logic                       s1_valid_q;
  logic [RESP_DATA_WIDTH-1:0] s1_data_q;
  logic [Lanes-1:0]           s1_top_q;
  logic [REQ_DATA_WIDTH-1:0]  s1_vec0_q;
  logic [REQ_DATA_WIDTH-1:0]  s1_vec1_q;
  logic [1:0]                 s1_esew_q;
  logic [1:0]                 s1_op_q;

  // Stage 2 state
  logic                       s2_valid_q;
  logic [RESP_DATA_WIDTH-1:0] out_data_q;
  logic [7:0]                 out_mask_q;

  logic adv1, adv2, s1_load, s2_load;

  assign adv2     = ~s2_valid_q | out_ready;
  assign adv1     = ~s1_valid_q | adv2;
  assign in_ready = adv1 & ~flush;
  assign s1_load  = in_valid & in_ready;
  assign s2_load  = s1_valid_q & adv2 & ~flush;

  assign out_valid = s2_valid_q;
  assign out_data  = out_data_q;
  assign out_mask  = out_mask_q;

  // Guard-bit unpacking of the incoming adder word
  logic [1:0]                 esew;
  logic [RESP_DATA_WIDTH-1:0] in_data;
  logic [Lanes-1:0]           in_top;
  logic                       unused_sum_bits;

  always_comb begin
    esew = sew[1:0];
    if (sew[1:0] == 2'b11 && !ENABLE_64_BIT) esew = 2'b10;
    in_data         = '0;
    in_top          = '0;
    unused_sum_bits = sum[RESP_DATA_WIDTH+16];
    for (int i = 0; i < Lanes; i++) begin
      in_data[8*i +: 8] = sum[10*i+1 +: 8];
      in_top[i]         = sum[10*i+9];
      unused_sum_bits   = unused_sum_bits ^ sum[10*i];
    end
  end

  // Flag and result formation from stage 1
  logic [2:0]                 grp;
  logic [2:0]                 top;
  logic [Lanes-1:0]           lane_flag;
  logic [RESP_DATA_WIDTH-1:0] res_data;
  logic [7:0]                 res_mask;

  always_comb begin
    case (s1_esew_q)
      2'b00:   grp = 3'd0;
      2'b01:   grp = 3'd1;
      2'b10:   grp = 3'd3;
      default: grp = 3'd7;
    endcase
    top       = '0;
    lane_flag = '0;
    res_data  = '0;
    res_mask  = '0;
    for (int i = 0; i < Lanes; i++) begin
      // Every lane of an element looks at the element's top lane.
      top          = 3'(i) | grp;
      lane_flag[i] = s1_op_q[1] ? s1_top_q[top] : ~s1_top_q[top];
      case (s1_op_q)
        2'b10:   res_data[8*i +: 8] = lane_flag[i] ? s1_vec0_q[8*i +: 8] : s1_vec1_q[8*i +: 8];
        2'b11:   res_data[8*i +: 8] = lane_flag[i] ? s1_vec1_q[8*i +: 8] : s1_vec0_q[8*i +: 8];
        default: res_data[8*i +: 8] = s1_data_q[8*i +: 8];
      endcase
    end
    for (int e = 0; e < 8; e++) begin
      if (e < (8 >> s1_esew_q)) res_mask[e] = lane_flag[3'(((e + 1) << s1_esew_q) - 1)];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_top_q   <= '0;
      s1_vec0_q  <= '0;
      s1_vec1_q  <= '0;
      s1_esew_q  <= '0;
      s1_op_q    <= '0;
      s2_valid_q <= 1'b0;
      out_data_q <= '0;
      out_mask_q <= '0;
    end else begin
      if (flush) begin
        s1_valid_q <= 1'b0;
        s2_valid_q <= 1'b0;
      end else begin
        if (adv1) s1_valid_q <= in_valid;
        if (adv2) s2_valid_q <= s1_valid_q;
      end
      if (s1_load) begin
        s1_data_q <= in_data;
        s1_top_q  <= in_top;
        s1_vec0_q <= vec0;
        s1_vec1_q <= vec1;
        s1_esew_q <= esew;
        s1_op_q   <= op;
      end
      if (s2_load) begin
        out_data_q <= res_data;
        out_mask_q <= res_mask;
      end
    end
  end

endmodule
